// File: rtl/chess_pkg.sv
// Shared piece codes, FSM states and move-offset tables
// for the sequential legal-move generator.
package chess_pkg;

  localparam logic [3:0] PC_EMPTY  = 4'h0;
  localparam logic [3:0] PC_W_ROOK = 4'h4;
  localparam logic [3:0] PC_B_ROOK = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SLIDE, S_JUMP,
    S_PAWN, S_CASTLE, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    PT_NONE, PT_PAWN, PT_BISHOP, PT_KNIGHT,
    PT_ROOK, PT_QUEEN, PT_KING
  } ptype_e;

  typedef logic signed [3:0] off_t;

  function automatic logic is_white(input logic [3:0] p);
    return (p >= 4'h1) && (p <= 4'h6);
  endfunction

  function automatic logic is_black(input logic [3:0] p);
    return (p >= 4'h7) && (p <= 4'hC);
  endfunction

  function automatic logic is_empty(input logic [3:0] p);
    return p == PC_EMPTY;
  endfunction

  function automatic ptype_e piece_type(input logic [3:0] p);
    if (is_white(p)) return ptype_e'(p[2:0]);
    if (is_black(p)) return ptype_e'(3'(p - 4'h6));
    return PT_NONE;
  endfunction

  // N,E,S,W then NE,SE,SW,NW; north is toward row 0
  function automatic off_t dir_dr(input logic [2:0] i);
    case (i)
      3'd0, 3'd4, 3'd7: return -4'sd1;
      3'd2, 3'd5, 3'd6: return 4'sd1;
      default:          return 4'sd0;
    endcase
  endfunction

  function automatic off_t dir_dc(input logic [2:0] i);
    case (i)
      3'd1, 3'd4, 3'd5: return 4'sd1;
      3'd3, 3'd6, 3'd7: return -4'sd1;
      default:          return 4'sd0;
    endcase
  endfunction

  function automatic off_t kn_dr(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: return -4'sd2;
      3'd2, 3'd3: return -4'sd1;
      3'd4, 3'd5: return 4'sd1;
      default:    return 4'sd2;
    endcase
  endfunction

  function automatic off_t kn_dc(input logic [2:0] i);
    case (i)
      3'd0, 3'd6: return -4'sd1;
      3'd1, 3'd7: return 4'sd1;
      3'd2, 3'd4: return -4'sd2;
      default:    return 4'sd2;
    endcase
  endfunction

endpackage

// File: rtl/square_eval.sv
// Resolves one candidate square relative to an origin
// and classifies its occupant against the mover colour.
module square_eval
  import chess_pkg::*;
(
  input  logic [5:0]           origin,
  input  logic signed [4:0]    d_row,
  input  logic signed [4:0]    d_col,
  input  logic                 white,
  input  logic [7:0][7:0][3:0] board,
  output logic                 on_board,
  output logic [5:0]           target_idx,
  output logic                 is_empty,
  output logic                 is_enemy
);

  logic signed [5:0] r;
  logic signed [5:0] c;
  logic [3:0]        sq;

  assign r = $signed({3'b000, origin[5:3]})
           + $signed({d_row[4], d_row});
  assign c = $signed({3'b000, origin[2:0]})
           + $signed({d_col[4], d_col});

  assign on_board   = (r[5:3] == 3'b000) &&
                      (c[5:3] == 3'b000);
  assign target_idx = {r[2:0], c[2:0]};
  assign sq         = board[r[2:0]][c[2:0]];
  assign is_empty   = on_board && (sq == PC_EMPTY);
  assign is_enemy   = on_board &&
                      (white ? is_black(sq) : is_white(sq));

endmodule

// File: rtl/move_generator.sv
// Sequential legal-destination mask generator: one
// candidate square per clock for the lifted piece.
module move_generator
  import chess_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           piece,
  input  logic [5:0]           pos,
  input  logic [7:0][7:0][3:0] board,
  input  logic [1:0]           castle_used,
  output logic [63:0]          possible_moves,
  output logic                 busy,
  output logic                 done
);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  dir_q, dir_d;
  logic [3:0]  piece_q, piece_d;
  logic [5:0]  pos_q, pos_d;
  logic [63:0] mask_q, mask_d;

  ptype_e            ptype;
  logic              white;
  logic [2:0]        sdir;
  logic [2:0]        last_dir;
  logic [3:0]        mag;
  off_t              fwd;
  logic signed [4:0] d_row, d_col;
  logic              on_board, tgt_empty, tgt_enemy;
  logic [5:0]        tgt_idx;
  logic              hit;
  logic [5:0]        hit_idx;
  logic [2:0]        home_row, start_row, mid_row;
  logic [3:0]        own_rook;
  logic              castle_ok, ks_ok, qs_ok, dbl_ok;

  function automatic logic signed [4:0] scale(
    input off_t u, input logic [3:0] m);
    if (u[3]) return -$signed({1'b0, m});
    if (u != 4'sd0) return $signed({1'b0, m});
    return 5'sd0;
  endfunction

  function automatic logic signed [4:0] ext(input off_t u);
    return {u[3], u};
  endfunction

  assign white    = is_white(piece_q);
  assign ptype    = piece_type(piece_q);
  assign sdir     = dir_q | {ptype == PT_BISHOP, 2'b00};
  assign last_dir = (ptype == PT_QUEEN) ? 3'd7 : 3'd3;
  assign mag      = {1'b0, step_q} + 4'd1;
  assign fwd      = white ? -4'sd1 : 4'sd1;

  always_comb begin
    d_row = 5'sd0;
    d_col = 5'sd0;
    unique case (state_q)
      S_SLIDE: begin
        d_row = scale(dir_dr(sdir), mag);
        d_col = scale(dir_dc(sdir), mag);
      end
      S_JUMP: begin
        d_row = ext(ptype == PT_KNIGHT ?
                    kn_dr(dir_q) : dir_dr(dir_q));
        d_col = ext(ptype == PT_KNIGHT ?
                    kn_dc(dir_q) : dir_dc(dir_q));
      end
      S_PAWN: begin
        d_row = ext(fwd);
        unique case (dir_q[1:0])
          2'd1:    d_row = {fwd, 1'b0};
          2'd2:    d_col = -5'sd1;
          2'd3:    d_col = 5'sd1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  square_eval u_eval (
    .origin     (pos_q),
    .d_row      (d_row),
    .d_col      (d_col),
    .white      (white),
    .board      (board),
    .on_board   (on_board),
    .target_idx (tgt_idx),
    .is_empty   (tgt_empty),
    .is_enemy   (tgt_enemy)
  );

  assign home_row  = white ? 3'd7 : 3'd0;
  assign own_rook  = white ? PC_W_ROOK : PC_B_ROOK;
  assign castle_ok = (pos_q == {home_row, 3'd4}) &&
                     !(white ? castle_used[0] :
                               castle_used[1]);
  assign ks_ok = castle_ok &&
                 is_empty(board[home_row][3'd5]) &&
                 is_empty(board[home_row][3'd6]) &&
                 (board[home_row][3'd7] == own_rook);
  assign qs_ok = castle_ok &&
                 is_empty(board[home_row][3'd1]) &&
                 is_empty(board[home_row][3'd2]) &&
                 is_empty(board[home_row][3'd3]) &&
                 (board[home_row][3'd0] == own_rook);

  // double push needs the skipped square clear too
  assign start_row = white ? 3'd6 : 3'd1;
  assign mid_row   = white ? 3'd5 : 3'd2;
  assign dbl_ok    = (pos_q[5:3] == start_row) &&
                     is_empty(board[mid_row][pos_q[2:0]]);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = dir_q;
    piece_d = piece_q;
    pos_d   = pos_q;
    mask_d  = mask_q;
    hit     = 1'b0;
    hit_idx = tgt_idx;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          piece_d = piece;
          pos_d   = pos;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        mask_d = '0;
        step_d = '0;
        dir_d  = '0;
        unique case (ptype)
          PT_BISHOP, PT_ROOK,
          PT_QUEEN:          state_d = S_SLIDE;
          PT_KNIGHT, PT_KING: state_d = S_JUMP;
          PT_PAWN:           state_d = S_PAWN;
          default:           state_d = S_DONE;
        endcase
      end
      S_SLIDE: begin
        if (tgt_empty) begin
          hit    = 1'b1;
          step_d = step_q + 3'd1;
        end else begin
          hit    = tgt_enemy;
          step_d = '0;
          if (dir_q == last_dir) state_d = S_DONE;
          else dir_d = dir_q + 3'd1;
        end
      end
      S_JUMP: begin
        hit   = tgt_empty || tgt_enemy;
        dir_d = dir_q + 3'd1;
        if (dir_q == 3'd7) begin
          state_d = (ptype == PT_KING) ?
                    S_CASTLE : S_DONE;
        end
      end
      S_PAWN: begin
        unique case (dir_q[1:0])
          2'd0:    hit = tgt_empty;
          2'd1:    hit = tgt_empty && dbl_ok;
          default: hit = tgt_enemy;
        endcase
        dir_d = dir_q + 3'd1;
        if (dir_q[1:0] == 2'd3) begin
          dir_d   = '0;
          state_d = S_DONE;
        end
      end
      S_CASTLE: begin
        if (dir_q[0]) begin
          hit     = qs_ok;
          hit_idx = {home_row, 3'd2};
          dir_d   = '0;
          state_d = S_DONE;
        end else begin
          hit     = ks_ok;
          hit_idx = {home_row, 3'd6};
          dir_d   = 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (hit) mask_d = mask_d | (64'd1 << hit_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      dir_q   <= '0;
      piece_q <= '0;
      pos_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      piece_q <= piece_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
    end
  end

  assign possible_moves = mask_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

endmodule

// File: doc/move_generator.md
# move_generator

Computes the legal-destination mask `possible_moves` for the piece just lifted from the board, sequentially, one candidate square per clock. It sits directly upstream of the board-state block. It is triggered on the same pick event that makes the board block latch the piece. Its 64-bit mask feeds both the board block's highlight logic (code 4'hD on empty legal squares) and the place-validation path.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `piece` in 4: code of the lifted piece (0 empty; 1–6 white P,B,N,R,Q,K; 7–C black P,B,N,R,Q,K).
- `pos` in 6: origin square; [5:3] row 0–7, [2:0] col 0–7; row 7 is the white back rank.
- `board` in 4 ×8×8: `[row][col]` piece codes; held stable by the caller while `busy`.
- `castle_used` in 2: bit0 white, bit1 black; castling already spent.
- `possible_moves` out 64: bit `row*8+col` set means a legal destination.
- `busy` out 1: generation in progress.
- `done` out 1: one-cycle pulse when the mask is final.

## Operation
- States: IDLE, INIT, SLIDE, JUMP, PAWN, CASTLE, DONE.
- **IDLE, `start` high:** latch `piece` and `pos`, go to INIT. When `start` is high in any other state it is ignored.
- **INIT:** clear the mask, zero the direction and step counters, then dispatch:
  - B/R/Q go to SLIDE.
  - N/K go to JUMP.
  - P goes to PAWN.
  - Code 0 or D–F goes straight to DONE with an all-zero mask.
- **Candidate rule:** a square is a target if it is on-board and either empty or holds the enemy colour. White is 1–6, black is 7–C.
- **SLIDE:** one candidate per cycle, at origin + (step+1)·dir.
  - Direction sets: R uses 4 orthogonal directions; B uses 4 diagonal; Q uses all 8 (orthogonal first: N,E,S,W, then NE,SE,SW,NW).
  - Empty: set the bit and continue in the same direction.
  - Enemy: set the bit, then advance direction.
  - Own piece or off-board: do not set the bit, advance direction.
  - Each off-board candidate costs one cycle.
  - After the last direction, go to DONE.
- **JUMP:** 8 fixed offsets, one per cycle, each tested with the candidate rule. Knight goes to DONE afterwards; king goes to CASTLE.
- **PAWN:** forward is row−1 for white and row+1 for black. Four fixed cycles, in order:
  1. Single push: set if empty.
  2. Double push: set if on the start row (white 6, black 1) and both squares are empty.
  3. Left capture: set if an enemy is there.
  4. Right capture: set if an enemy is there.
- **CASTLE:** two cycles.
  - Kingside: set g-file bit (62 white / 6 black) when all hold: king on e-file home (60/4), own `castle_used` bit is 0, f and g are empty, own rook is on h.
  - Queenside: set c-file bit (58/2) when b, c, d are empty and own rook is on a.
- **DONE:** pulse `done`, return to IDLE. The mask holds until the next INIT.
- Check and pinning are out of scope.

## Timing
- **Reset:** `possible_moves`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- **Reset mid-generation:** immediate abort to these values; no `done`.
- **Latency:**
  - `start` is sampled at edge N; `busy` is high from N+1 through the DONE cycle.
  - INIT occupies cycle N+1; evaluations start at N+2.
  - `done` is high in the cycle after the last evaluation.
  - Knight: `done` at N+10. Pawn: N+6. King: N+12. Empty piece: N+2.
  - Slider latency = 2 + (number of candidates evaluated, including the terminating one).
- **Mask update:** bits are OR-ed in on the evaluation edge. The mask is final and stable when `done`=1.
- **Back-to-back:** `start` in the same cycle as `done` is ignored. It is accepted from the following IDLE cycle.
- **Step counter:** 3 bits; a direction always terminates by step 7.

## Structure
- **`chess_pkg`:** piece-code localparams, `is_white`/`is_black`/`is_empty` functions, state enum, 8-entry direction and knight-offset tables (signed 4-bit Δrow/Δcol).
- **`square_eval`:** one combinational sub-module. Inputs are origin, Δrow, Δcol, mover colour and board. Outputs are `on_board`, `target_idx[5:0]`, `is_empty`, `is_enemy`.

## Test plan
- **Initial board, knight:** white knight `pos`=57 → mask bits {40,42} only; `done` at N+10.
- **Initial board, pawn:** white pawn `pos`=52 → bits {44,36}; black pawn `pos`=12 → bits {20,28}.
- **Queen on empty board:** only the queen, `pos`=27 → popcount 27, including bits 3, 31, 0, 63.
- **King castling:** white king at 60, rooks at 56/63, rank 7 otherwise empty, `castle_used`=0 → bits 58 and 62 set. Repeat with `castle_used`=01 → both clear.
- **Start while busy:** `start` pulsed at N+3 during a rook scan → ignored; mask and `done` timing unchanged.
- **Reset mid-operation:** `rst` low at N+4 → all outputs 0 asynchronously; after release, a new `start` generates correctly.
